// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Issues one multi-cycle MDU operation at a time (divide, low-performance
// multiply, carry-less multiply), stalls the pipeline while it runs, resolves
// divide-by-zero and signed-overflow divides without the divider, and holds
// the result until writeback acknowledges it. Supports pipeline kill and a
// watchdog that aborts a unit that never answers.

module mdu_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        issue_valid,
  input  logic        issue_div,
  input  logic        issue_mul,
  input  logic        issue_clmul,
  input  logic [2:0]  issue_funct3,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic [4:0]  issue_waddr,
  input  logic        kill,

  output logic        div_start,
  output logic        mul_start,
  output logic        clmul_start,
  output logic [2:0]  unit_funct3,
  output logic [31:0] unit_rs1,
  output logic [31:0] unit_rs2,
  output logic        unit_flush,

  input  logic        div_ready,
  input  logic        mul_ready,
  input  logic        clmul_ready,
  input  logic [31:0] div_result,
  input  logic [31:0] mul_result,
  input  logic [31:0] clmul_result,

  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_data,
  input  logic        wb_ack,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_DIV   = 3'd1,
    WAIT_MUL   = 3'd2,
    WAIT_CLMUL = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_funct3;
  logic [31:0]   r_rs1;
  logic [31:0]   r_rs2;
  logic [4:0]    r_waddr;
  logic [31:0]   r_wb_data;

  logic          w_anyFlag;
  logic          w_accept;
  logic          w_divZero;
  logic          w_overflow;
  logic          w_fastPath;
  logic [31:0]   w_fastData;
  logic          w_readySel;
  logic [31:0]   w_resultSel;
  logic          w_capture;
  logic          w_countUp;

  // An operation is taken only from IDLE, only if some unit is flagged, and never under kill.
  assign w_anyFlag = issue_div | issue_mul | issue_clmul;
  assign w_accept  = (r_state == IDLE) & issue_valid & w_anyFlag & ~kill;

  // Divide corner cases are answered directly; funct3[1] selects remainder, funct3[0] unsigned.
  assign w_divZero  = (issue_rs2 == 32'h0000_0000);
  assign w_overflow = ~issue_funct3[0] & (issue_rs1 == 32'h8000_0000) & (issue_rs2 == 32'hFFFF_FFFF);
  assign w_fastPath = issue_div & (w_divZero | w_overflow);

  // Result of the fast path: quotient all-ones or remainder = dividend on /0, MIN or 0 on overflow.
  always_comb begin
    w_fastData = 32'h0000_0000;
    if (w_divZero) begin
      w_fastData = issue_funct3[1] ? issue_rs1 : 32'hFFFF_FFFF;
    end else begin
      w_fastData = issue_funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // Only the unit that was actually started may complete the wait; other ready pulses are ignored.
  always_comb begin
    w_readySel  = 1'b0;
    w_resultSel = 32'h0000_0000;
    unique case (r_state)
      WAIT_DIV: begin
        w_readySel  = div_ready;
        w_resultSel = div_result;
      end
      WAIT_MUL: begin
        w_readySel  = mul_ready;
        w_resultSel = mul_result;
      end
      WAIT_CLMUL: begin
        w_readySel  = clmul_ready;
        w_resultSel = clmul_result;
      end
      default: begin
        w_readySel  = 1'b0;
        w_resultSel = 32'h0000_0000;
      end
    endcase
  end

  // Next-state and pulse outputs; kill outranks ready, which outranks the watchdog.
  always_comb begin
    w_next      = r_state;
    div_start   = 1'b0;
    mul_start   = 1'b0;
    clmul_start = 1'b0;
    unit_flush  = 1'b0;
    timeout_err = 1'b0;
    w_capture   = 1'b0;
    w_countUp   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (issue_div) begin
            w_next = w_fastPath ? DONE : WAIT_DIV;
          end else if (issue_mul) begin
            w_next = WAIT_MUL;
          end else begin
            w_next = WAIT_CLMUL;
          end
        end
      end
      WAIT_DIV, WAIT_MUL, WAIT_CLMUL: begin
        div_start   = (r_state == WAIT_DIV)   && (r_cnt == '0);
        mul_start   = (r_state == WAIT_MUL)   && (r_cnt == '0);
        clmul_start = (r_state == WAIT_CLMUL) && (r_cnt == '0);
        if (kill) begin
          unit_flush = 1'b1;
          w_next     = IDLE;
        end else if (w_readySel) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end else if (r_cnt == CNT_LAST) begin
          timeout_err = 1'b1;
          unit_flush  = 1'b1;
          w_next      = IDLE;
        end else begin
          w_countUp = 1'b1;
        end
      end
      DONE: begin
        if (kill || wb_ack) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand latch, watchdog counter and writeback data; counter restarts on every accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_funct3  <= 3'd0;
      r_rs1     <= 32'h0000_0000;
      r_rs2     <= 32'h0000_0000;
      r_waddr   <= 5'd0;
      r_wb_data <= 32'h0000_0000;
    end else begin
      if (w_accept) begin
        r_funct3 <= issue_funct3;
        r_rs1    <= issue_rs1;
        r_rs2    <= issue_rs2;
        r_waddr  <= issue_waddr;
        r_cnt    <= '0;
        if (w_fastPath) begin
          r_wb_data <= w_fastData;
        end
      end else begin
        if (w_countUp) begin
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_capture) begin
          r_wb_data <= w_resultSel;
        end
      end
    end
  end

  assign unit_funct3 = r_funct3;
  assign unit_rs1    = r_rs1;
  assign unit_rs2    = r_rs2;
  assign wb_waddr    = r_waddr;
  assign wb_data     = r_wb_data;
  assign wb_valid    = (r_state == DONE);
  assign stall       = w_accept | ((r_state != IDLE) & ~((r_state == DONE) & wb_ack));

endmodule
